uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_pkg.sv | 25 ++
 rtl/byte_fifo.sv | 62 ++++++
 rtl/uart_tx_buf.sv | 143 ++++++++++++++
 tb/tb_uart_tx_buf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared FSM state type and frame constants for the UART
//               transmitter. UART_TX_PARITY_EN adds the PARITY state.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   DEFAULT_CLKS_PER_BIT = 1086;
    localparam int   DATA_BITS            = 8;
    localparam logic IDLE_LEVEL           = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Power-of-two deep synchronous FIFO with occupancy count;
//               push when full and pop when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_pop_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (c_AW + 1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buf
// Description : Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for
//               an even parity bit between data and stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [15:0] c_CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_IDX_LAST = 3'(DATA_BITS - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [15:0]                r_bit_cnt;
    logic [2:0]                 r_bit_idx;
    logic [DATA_BITS-1:0]       r_shift;
    logic                       r_tx;
    logic                       w_tx_next;
    logic                       w_bit_done;
    logic                       w_pop;
    logic [DATA_BITS-1:0]       w_fifo_head;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                       w_fifo_empty;
    logic                       w_fifo_full;
`ifdef UART_TX_PARITY_EN
    logic                       r_parity;
`endif

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (in_valid && in_ready),
        .i_push_data (in_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    assign w_bit_done = (r_bit_cnt == c_CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = IDLE_LEVEL;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_bit_done) w_state_next = DATA;
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (w_bit_done && r_bit_idx == c_IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_next = r_parity;
                if (w_bit_done) w_state_next = STOP;
            end
`endif
            STOP: begin
                w_tx_next = IDLE_LEVEL;
                // Chain straight into the next frame when bytes are waiting
                if (w_bit_done) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // tx is registered from the current state, so the line lags the state by one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            if (r_state == IDLE || w_bit_done) r_bit_cnt <= '0;
            else                               r_bit_cnt <= r_bit_cnt + 16'd1;
            if (w_pop) begin
                r_shift   <= w_fifo_head;
                r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                r_parity  <= ^w_fifo_head;
`endif
            end else if (r_state == DATA && w_bit_done) begin
                r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    assign tx         = r_tx;
    assign in_ready   = !w_fifo_full;
    assign fifo_count = w_fifo_count;
    assign busy       = (r_state != IDLE) || (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buf
// Description : Self-checking bench for uart_tx_buf against a frame-level
//               model; honours UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_buf;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_buf #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         edge_n = 0;
    int         free_at = 0;
    int         fr_t = -100000;
    logic [7:0] fr_b = 8'h00;
    logic [7:0] mq[$];
    logic       txlog[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bit k of byte b: start, data LSB first, optional even parity, stop
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic lg(input int ed);
        if (ed < 1 || ed > txlog.size()) return 1'bx;
        return txlog[ed-1];
    endfunction

    // One clock: the transmitter takes a byte whenever it is free and the buffer
    // holds one; each byte occupies it for FRAME cycles.
    task automatic step(input string tag);
        int         pre;
        int         k;
        logic       rst_pre;
        logic       val_pre;
        logic [7:0] dat_pre;
        logic       exp_tx;
        pre     = mq.size();
        rst_pre = rst_n;
        val_pre = in_valid;
        dat_pre = in_data;
        @(posedge clk);
        #1;
        edge_n++;
        if (!rst_pre) begin
            mq.delete();
            free_at = edge_n;
            fr_t    = -100000;
            exp_tx  = 1'b1;
        end else begin
            k      = edge_n - fr_t - 1;
            exp_tx = (k >= 0 && k < FRAME) ? frame_bit(fr_b, k / CPB) : 1'b1;
            if (edge_n >= free_at && pre > 0) begin
                fr_b    = mq.pop_front();
                fr_t    = edge_n;
                free_at = edge_n + FRAME;
            end
            if (val_pre && pre != DEPTH) mq.push_back(dat_pre);
        end
        txlog.push_back(tx);
        check({tag, ".tx"}, 32'(tx), 32'(exp_tx));
        check({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
        check({tag, ".ready"}, 32'(in_ready), 32'(mq.size() != DEPTH));
        check({tag, ".busy"}, 32'(busy), 32'(mq.size() != 0 || edge_n < free_at));
    endtask

    task automatic push1(input logic [7:0] b, input string tag);
        in_data  = b;
        in_valid = 1'b1;
        step(tag);
        in_valid = 1'b0;
    endtask

    initial begin
        int         pe;
        int         rt;
        logic [10:0] seq;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step("reset");
        check("rst.tx", 32'(tx), 32'd1);
        check("rst.count", 32'(fifo_count), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) step("idle");

        // Single byte 0x41: fall 2 cycles after the push edge, fixed bit pattern
        push1(8'h41, "p41");
        pe = edge_n;
        repeat (FRAME + 10) step("f41");
        check("p41.pre_fall", 32'(lg(pe + 1)), 32'd1);
        check("p41.fall", 32'(lg(pe + 2)), 32'd0);
`ifdef UART_TX_PARITY_EN
        seq = 11'b100_1000_0010;
`else
        seq = 11'b010_1000_0010;
`endif
        for (int j = 0; j < NBITS; j++) begin
            check($sformatf("p41.bit%0d", j),
                  32'({lg(pe + 2 + j*CPB), lg(pe + 3 + j*CPB), lg(pe + 4 + j*CPB), lg(pe + 5 + j*CPB)}),
                  32'({4{seq[j]}}));
        end
        check("p41.after", 32'(lg(pe + 2 + FRAME)), 32'd1);
        check("p41.busy_end", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        push1(8'h07, "p07");
        pe = edge_n;
        repeat (FRAME + 4) step("f07");
        check("p07.parity", 32'(lg(pe + 2 + 9*CPB + 1)), 32'd1);
`endif

        // Two back-to-back bytes: no idle cycle between frames
        in_data  = 8'h55;
        in_valid = 1'b1;
        step("p55");
        pe = edge_n;
        in_data = 8'hAA;
        step("pAA");
        in_valid = 1'b0;
        repeat (2 * FRAME + 10) step("f55aa");
        check("b2b.fall1", 32'(lg(pe + 2)), 32'd0);
        check("b2b.stop1", 32'(lg(pe + 1 + FRAME)), 32'd1);
        check("b2b.fall2", 32'(lg(pe + 2 + FRAME)), 32'd0);
        check("b2b.end", 32'(lg(pe + 2 + 2*FRAME)), 32'd1);

        // Hold in_valid for 6 random bytes: fill to 4, excess dropped
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom_range(0, 255));
            step("hold6");
        end
        in_valid = 1'b0;
        check("hold6.full", 32'(fifo_count), 32'd4);

        // Keep pushing into the full buffer across the next pop edge
        in_valid = 1'b1;
        for (int i = 0; i < FRAME + 6; i++) begin
            in_data = 8'($urandom_range(0, 255));
            step("fullpop");
        end
        in_valid = 1'b0;
        repeat (6 * FRAME) step("drain1");

        // Reset during data bit 3 with two bytes queued
        push1(8'($urandom_range(0, 255)), "rq0");
        push1(8'($urandom_range(0, 255)), "rq1");
        push1(8'($urandom_range(0, 255)), "rq2");
        check("rst_mid.q2", 32'(fifo_count), 32'd2);
        rt = fr_t;
        while (edge_n < rt + 17) step("to_bit3");
        rst_n = 1'b0;
        step("rst_mid");
        check("rst_mid.tx", 32'(tx), 32'd1);
        check("rst_mid.count", 32'(fifo_count), 32'd0);
        check("rst_mid.ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        repeat (3 * FRAME) step("post_rst");

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom_range(0, 255));
            step("rand");
        end
        in_valid = 1'b0;
        repeat (6 * FRAME) step("drain2");
        check("final.idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
